// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Start/busy/done handshake; any digit above 9 forces a zero result with error.
module bcd_to_binary_seq #(
    parameter int NDIGITS = 2,
    parameter int OUT_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [OUT_W-1:0]       binary_out,
    output logic                   error
);

    localparam int AW = OUT_W + 4;
    localparam int SW = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [SW-1:0]       r_sr;
    logic [OUT_W-1:0]    r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_err;
    logic                r_busy;
    logic                r_done;
    logic [OUT_W-1:0]    r_out;
    logic                r_out_err;

    logic [3:0]          w_d;
    logic [AW-1:0]       w_ext;
    logic [AW-1:0]       w_next;
    logic                w_bad;
    logic                w_err;

    assign w_d    = r_sr[SW-1 -: 4];
    assign w_ext  = AW'(r_acc);
    // acc*10 as shift-add, widened so the final 10^N - 1 is exact
    assign w_next = (w_ext << 3) + (w_ext << 1) + AW'(w_d);
    assign w_bad  = (w_d > 4'd9);
    assign w_err  = r_err | w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_out     <= '0;
            r_out_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr    <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_next[OUT_W-1:0];
                    r_sr  <= r_sr << 4;
                    r_err <= w_err;
                    if (r_cnt == LAST) begin
                        r_out     <= w_err ? '0 : w_next[OUT_W-1:0];
                        r_out_err <= w_err;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign binary_out = r_out;
    assign error      = r_out_err;

endmodule
